// File: rtl/i2c_slave_controller_if.sv
// i2c_slave_controller_if: SCL/SDA pins, data_transmitter hand-off and user read/write ports.
interface i2c_slave_controller_if;
   logic       scl_i;
   logic       sda_i;
   logic       scl_neg_edge_o;
   logic       tx_en_o;
   logic [7:0] tx_data_o;
   logic       rd_req_o;
   logic [7:0] rd_data_i;
   logic [7:0] wr_data_o;
   logic       wr_valid_o;
   logic       sda_ack_o;
   logic       busy_o;
   modport slave (
      input  scl_i, sda_i, rd_data_i,
      output scl_neg_edge_o, tx_en_o, tx_data_o, rd_req_o, wr_data_o, wr_valid_o, sda_ack_o, busy_o
   );
   modport master (
      output scl_i, sda_i, rd_data_i,
      input  scl_neg_edge_o, tx_en_o, tx_data_o, rd_req_o, wr_data_o, wr_valid_o, sda_ack_o, busy_o
   );
endinterface

// File: rtl/i2c_slave_controller.sv
// i2c_slave_controller: I2C slave front end (sync, START/STOP, address match, write bytes, ACK, read hand-off).
// Define I2C_GENERAL_CALL_EN to also accept address byte 8'h00 as a write.
module i2c_slave_controller #(
   parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
   input logic                   clk_i,
   input logic                   reset_n_i,
   i2c_slave_controller_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP} state_t;
   state_t     r_state;
   logic [2:0] r_scl_s, r_sda_s;
   logic [3:0] r_cnt;
   logic [6:0] r_shift;
   logic [7:0] r_tx_data, r_wr_data;
   logic       r_rw, r_tx_pend, r_neg, r_tx_en, r_rd_req, r_wr_valid, r_sda_ack, r_busy;
   logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_match;
   logic [7:0] w_byte;
   assign w_scl_rise = r_scl_s[1] & ~r_scl_s[2];
   assign w_scl_fall = ~r_scl_s[1] & r_scl_s[2];
   // SCL high in both taps means no SCL edge this cycle
   assign w_start = r_scl_s[1] & r_scl_s[2] & ~r_sda_s[1] & r_sda_s[2];
   assign w_stop  = r_scl_s[1] & r_scl_s[2] & r_sda_s[1] & ~r_sda_s[2];
   assign w_byte  = {r_shift, r_sda_s[1]};
`ifdef I2C_GENERAL_CALL_EN
   assign w_match = (w_byte[7:1] == SLAVE_ADDR) || (w_byte == 8'h00);
`else
   assign w_match = w_byte[7:1] == SLAVE_ADDR;
`endif
   assign bus.scl_neg_edge_o = r_neg;
   assign bus.tx_en_o        = r_tx_en;
   assign bus.tx_data_o      = r_tx_data;
   assign bus.rd_req_o       = r_rd_req;
   assign bus.wr_data_o      = r_wr_data;
   assign bus.wr_valid_o     = r_wr_valid;
   assign bus.sda_ack_o      = r_sda_ack;
   assign bus.busy_o         = r_busy;
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state    <= IDLE;
         r_scl_s    <= 3'b111;
         r_sda_s    <= 3'b111;
         r_cnt      <= 4'd0;
         r_shift    <= 7'd0;
         r_rw       <= 1'b0;
         r_tx_pend  <= 1'b0;
         r_neg      <= 1'b0;
         r_tx_en    <= 1'b0;
         r_tx_data  <= 8'hFF;
         r_rd_req   <= 1'b0;
         r_wr_data  <= 8'h00;
         r_wr_valid <= 1'b0;
         r_sda_ack  <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         r_scl_s    <= {r_scl_s[1:0], bus.scl_i};
         r_sda_s    <= {r_sda_s[1:0], bus.sda_i};
         r_neg      <= w_scl_fall;
         r_rd_req   <= 1'b0;
         r_wr_valid <= 1'b0;
         r_tx_pend  <= 1'b0;
         // enable rises one cycle after scl_neg_edge_o so the transmitter sees them apart
         if (r_tx_pend) r_tx_en <= 1'b1;
         if (w_scl_rise) r_shift <= w_byte[6:0];
         if (w_start) begin
            r_state   <= ADDR;
            r_cnt     <= 4'd0;
            r_tx_en   <= 1'b0;
            r_sda_ack <= 1'b1;
         end else if (w_stop) begin
            r_state   <= IDLE;
            r_tx_en   <= 1'b0;
            r_sda_ack <= 1'b1;
            r_busy    <= 1'b0;
         end else begin
            case (r_state)
               IDLE: ;
               ADDR: begin
                  if (w_scl_rise) begin
                     r_cnt <= r_cnt + 4'd1;
                     if (r_cnt == 4'd7 && w_match) begin
                        r_rw   <= w_byte[0];
                        r_busy <= 1'b1;
                     end else if (r_cnt == 4'd7) begin
                        r_state <= WAIT_STOP;
                        r_busy  <= 1'b0;
                     end
                  end
                  if (w_scl_fall && r_cnt == 4'd8) begin
                     r_state   <= ADDR_ACK;
                     r_sda_ack <= 1'b0;
                  end
               end
               ADDR_ACK: begin
                  if (w_scl_rise && r_rw) r_rd_req <= 1'b1;
                  if (w_scl_fall) begin
                     r_sda_ack <= 1'b1;
                     r_tx_data <= bus.rd_data_i;
                     r_cnt     <= 4'd0;
                     r_tx_pend <= r_rw;
                     r_state   <= r_rw ? READ : WRITE;
                  end
               end
               WRITE: begin
                  if (w_scl_rise) begin
                     r_cnt <= r_cnt + 4'd1;
                     if (r_cnt == 4'd7) begin
                        r_wr_data  <= w_byte;
                        r_wr_valid <= 1'b1;
                     end
                  end
                  if (w_scl_fall && r_cnt == 4'd8) begin
                     r_sda_ack <= 1'b0;
                     r_state   <= WRITE_ACK;
                  end
               end
               WRITE_ACK: begin
                  if (w_scl_fall) begin
                     r_sda_ack <= 1'b1;
                     r_cnt     <= 4'd0;
                     r_state   <= WRITE;
                  end
               end
               READ: begin
                  if (w_scl_fall) begin
                     r_cnt <= (r_cnt == 4'd7) ? 4'd0 : r_cnt + 4'd1;
                     if (r_cnt == 4'd7) r_state <= READ_ACK;
                  end
               end
               READ_ACK: begin
                  // r_cnt flags that the master ACKed and the next byte is due on the fall
                  if (w_scl_rise) begin
                     r_tx_en <= 1'b0;
                     if (!r_sda_s[1]) begin
                        r_rd_req <= 1'b1;
                        r_cnt    <= 4'd1;
                     end else begin
                        r_busy  <= 1'b0;
                        r_state <= WAIT_STOP;
                     end
                  end else if (w_scl_fall && r_cnt == 4'd1) begin
                     r_tx_data <= bus.rd_data_i;
                     r_tx_pend <= 1'b1;
                     r_cnt     <= 4'd0;
                     r_state   <= READ;
                  end
               end
               WAIT_STOP: begin
                  r_sda_ack <= 1'b1;
                  r_tx_en   <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: doc/i2c_slave_controller.md
Name: i2c_slave_controller

Overview:
- Bit/byte-level I2C slave front end that sits directly upstream of data_transmitter.
- Synchronises SCL/SDA and detects START, repeated START and STOP.
- Shifts in and matches the address, receives write bytes and drives ACK.
- Supplies data_transmitter with scl_neg_edge, enable and a byte held stable for the whole read byte.

Parameters:
SLAVE_ADDR, 7'h42, 7-bit slave address matched against the first byte after START.

Ports:
clk_i  input  1  system clock, at least 10x SCL rate
reset_n_i  input  1  asynchronous reset, active low
scl_i  input  1  raw SCL pin input (asynchronous)
sda_i  input  1  raw SDA pin input (asynchronous)
scl_neg_edge_o  output  1  one-cycle pulse per synchronised SCL falling edge; feeds transmitter scl_neg_edge_detected_i
tx_en_o  output  1  transmitter enable; high for the duration of each read byte
tx_data_o  output  8  read byte to transmitter data_i; stable while tx_en_o high
rd_req_o  output  1  one-cycle pulse requesting the next read byte from user logic
rd_data_i  input  8  user read data; captured half an SCL period after rd_req_o
wr_data_o  output  8  last received write byte
wr_valid_o  output  1  one-cycle pulse, wr_data_o valid
sda_ack_o  output  1  slave ACK drive; 0 pulls SDA low; top level ANDs it with transmitter sda_o
busy_o  output  1  high from address match until STOP/NACK/mismatch

Behaviour:
- Sync: scl_i and sda_i each pass through a 2-FF synchroniser, plus a third FF for edge detect.
  - scl_rise/scl_fall are single-cycle strobes; scl_neg_edge_o = scl_fall, registered.
- START = synced SDA falling while synced SCL high. STOP = synced SDA rising while SCL high.
  - SDA changes are evaluated only when SCL shows no edge in that cycle.
- Data bits are sampled MSB first on scl_rise.
- FSM states: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
- START from any state (repeated START included):
  - -> ADDR; bit counter = 0; tx_en_o=0; sda_ack_o=1.
- STOP from any state: -> IDLE; tx_en_o=0; sda_ack_o=1; busy_o=0.
- ADDR: shift 8 bits. On the 8th scl_rise compare bits[7:1] with SLAVE_ADDR.
  - Match: latch R/W bit, busy_o=1; on the next scl_fall -> ADDR_ACK with sda_ack_o=0.
  - Mismatch: -> WAIT_STOP; sda_ack_o stays 1.
- ADDR_ACK:
  - If R/W=1, pulse rd_req_o on the 9th scl_rise.
  - On the following scl_fall: sda_ack_o=1; tx_data_o<=rd_data_i.
  - Read: tx_en_o=1 in the cycle after that scl_fall, -> READ. Write: -> WRITE.
- WRITE: shift 8 bits.
  - On the 8th scl_rise: wr_data_o<=byte, wr_valid_o pulses one cycle.
  - On the next scl_fall: sda_ack_o=0, -> WRITE_ACK.
  - On the following scl_fall: sda_ack_o=1, -> WRITE.
- READ: the transmitter shifts bits itself. Count 8 scl_fall strobes, then -> READ_ACK.
  - The transmitter has released SDA by that point.
- READ_ACK: on scl_rise deassert tx_en_o and sample SDA.
  - SDA=0 (ACK): pulse rd_req_o the same cycle; on the next scl_fall load tx_data_o, reassert tx_en_o, -> READ.
  - SDA=1 (NACK): busy_o=0, -> WAIT_STOP.
- tx_en_o is always low for at least one SCL half-period between bytes, so the transmitter sees a fresh rising edge per byte.
- tx_en_o never rises in the same cycle as scl_neg_edge_o.
- WAIT_STOP: all outputs released; only START/STOP leave it.
- Reset values:
  - sda_ack_o=1, tx_en_o=0, tx_data_o=8'hFF, wr_data_o=8'h00.
  - wr_valid_o=0, rd_req_o=0, scl_neg_edge_o=0, busy_o=0.
  - FSM=IDLE; synchroniser FFs=1.
- Reset asserted mid-transfer releases SDA immediately (asynchronous). The block resumes only on the next START.

Optional Feature:
- Macro I2C_GENERAL_CALL_EN.
- Defined: address byte 8'h00 is also accepted and ACKed, and the block proceeds as WRITE. busy_o=1.
- Undefined: 8'h00 is treated as a mismatch -> WAIT_STOP, no ACK.

Test Plan:
- START, addr 0x84 (0x42 write), data 0xA5, STOP -> ACK low on 9th clocks of both bytes; wr_valid_o one pulse with wr_data_o=0xA5; busy_o low after STOP.
- START, addr 0x85, rd_data_i=0x3C, master ACK, rd_data_i=0xC3, master NACK, STOP -> transmitter drives 0x3C then 0xC3; rd_req_o pulses twice; tx_en_o low between bytes; SDA released after NACK.
- START, addr 0x90 (mismatch), 0x55, STOP -> sda_ack_o never 0; no wr_valid_o; busy_o stays 0.
- Write 0x11, then repeated START with addr 0x85 read mid-transaction -> WRITE aborted cleanly; read of rd_data_i proceeds; no spurious wr_valid_o.
- reset_n_i pulled low during bit 4 of a read byte -> tx_en_o=0 and sda_ack_o=1 within the reset; the next full transaction completes normally.
- With I2C_GENERAL_CALL_EN: START, addr 0x00, 0x06 -> ACK + wr_valid_o (0x06). Without it: no ACK.
